// File: rtl/mul_sequencer.sv
// mul_sequencer: radix-2 shift-add multiply sequencer for the MIPS core.
// Runs MUL/MULT/MULTU over 32 iteration cycles, owns HI/LO, and freezes
// IF/ID while a multiply is in flight. The MUL low word goes back to ID.

module mul_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mul_op,
  input  logic [31:0] op_x,
  input  logic [31:0] op_y,
  input  logic        hold,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic        stall,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;

  state_t      state_q;
  logic [4:0]  count_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;
  logic        neg_q;
  logic        isMul_q;
  logic        busy_q;
  logic        valid_q;
  logic [31:0] result_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        isMult;
  logic [31:0] absX;
  logic [31:0] absY;
  logic [63:0] addend;
  logic [63:0] acc_d;
  logic [63:0] product_d;

  // Operand conditioning: MULT works on magnitudes and fixes the sign at
  // the end; abs of 0x80000000 wraps to itself, which is the right unsigned
  // magnitude. MUL, MULTU and the reserved encoding use the raw operands.
  always_comb begin
    isMult = (mul_op == OP_MULT);
    absX   = op_x[31] ? (~op_x + 32'd1) : op_x;
    absY   = op_y[31] ? (~op_y + 32'd1) : op_y;
  end

  // One shift-add step; on the final step this sum is the full magnitude,
  // which is negated here when the MULT operands had opposite signs.
  always_comb begin
    addend    = mplier_q[0] ? mcand_q : 64'd0;
    acc_d     = acc_q + addend;
    product_d = neg_q ? (~acc_d + 64'd1) : acc_d;
  end

  // Sequencer state, datapath registers, HI/LO and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      isMul_q  <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mthi_we) begin
            hi_q <= mt_data;
          end
          if (mtlo_we) begin
            lo_q <= mt_data;
          end
          if (start) begin
            mcand_q  <= {32'd0, (isMult ? absX : op_x)};
            mplier_q <= isMult ? absY : op_y;
            neg_q    <= isMult & (op_x[31] ^ op_y[31]);
            isMul_q  <= (mul_op == OP_MUL);
            acc_q    <= 64'd0;
            count_q  <= 5'd0;
            busy_q   <= 1'b1;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          count_q  <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            if (isMul_q) begin
              result_q <= product_d[31:0];
            end else begin
              hi_q <= product_d[63:32];
              lo_q <= product_d[31:0];
            end
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!hold) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Freeze IF/ID from the cycle the multiply is first seen until the last
  // iteration; DONE releases the pipe so the MUL can leave ID.
  always_comb begin
    stall = ((state_q == IDLE) & start) | (state_q == BUSY);
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule
